// File: rtl/intc_trap_seq.sv
// ---------------------------------------------------------------------------
// intc_trap_seq
//   Multi-source interrupt arbiter and trap sequencer for the MCU core.
//   Rising edges on irq_in are latched as pending, masked by en_mask and
//   arbitrated by fixed priority (lowest index wins). A one-cycle int_taken
//   strobe is issued at an instruction boundary when mstatus.MIE is set.
//   After that no further trap is taken until mret_exec.
//
//   Optional feature: define INTC_IRQ_SYNC_EN to insert a two-flop
//   synchronizer on irq_in ahead of edge detection. This allows asynchronous
//   sources and adds two clocks of latency.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   irq_in     in   [NUM_SRC] interrupt request lines, rising-edge sensitive
//   mie        in   mstatus.MIE from the CSR file
//   boundary   in   core is at an instruction boundary this cycle
//   mret_exec  in   mret executing this cycle
//   en_we      in   enable-mask write strobe
//   en_wd      in   [NUM_SRC] enable-mask write data
//   en_mask    out  [NUM_SRC] current enable mask
//   pending    out  [NUM_SRC] latched pending bits
//   int_taken  out  registered one-cycle trap strobe
//   irq_id     out  [8] index of the claimed source, zero-extended
//   in_handler out  trap handler active (TAKE or HANDLER)
// ---------------------------------------------------------------------------
module intc_trap_seq #(
    parameter int NUM_SRC = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               mie,
    input  logic               boundary,
    input  logic               mret_exec,
    input  logic               en_we,
    input  logic [NUM_SRC-1:0] en_wd,
    output logic [NUM_SRC-1:0] en_mask,
    output logic [NUM_SRC-1:0] pending,
    output logic               int_taken,
    output logic [7:0]         irq_id,
    output logic               in_handler
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TAKE    = 2'd1,
        ST_HANDLER = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [NUM_SRC-1:0] irq_s;
    logic [NUM_SRC-1:0] irq_prev_r;
    logic [NUM_SRC-1:0] rise_s;
    logic [NUM_SRC-1:0] pending_r;
    logic [NUM_SRC-1:0] en_mask_r;
    logic [NUM_SRC-1:0] eligible_s;
    logic [NUM_SRC-1:0] clr_s;
    logic [7:0]         winner_s;
    logic               take_s;
    logic [7:0]         irq_id_r;
    logic               int_taken_r;
    logic               in_handler_r;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [7:0] lowest_index(input logic [NUM_SRC-1:0] vec);
        logic [7:0] idx;
        idx = 8'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 8'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // One-hot decode of a source index, limited to NUM_SRC bits.
    function automatic logic [NUM_SRC-1:0] onehot(input logic [7:0] idx);
        logic [NUM_SRC-1:0] vec;
        vec = {NUM_SRC{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            if (idx == 8'(i)) begin
                vec[i] = 1'b1;
            end else begin
                vec[i] = 1'b0;
            end
        end
        return vec;
    endfunction

`ifdef INTC_IRQ_SYNC_EN
    logic [NUM_SRC-1:0] sync1_r;
    logic [NUM_SRC-1:0] sync2_r;

    // Two-flop synchronizer for asynchronous interrupt sources.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= {NUM_SRC{1'b0}};
            sync2_r <= {NUM_SRC{1'b0}};
        end else begin
            sync1_r <= irq_in;
            sync2_r <= sync1_r;
        end
    end

    assign irq_s = sync2_r;
`else
    assign irq_s = irq_in;
`endif

    assign rise_s     = irq_s & ~irq_prev_r;
    assign eligible_s = pending_r & en_mask_r;
    assign winner_s   = lowest_index(eligible_s);

    // Next-state logic and claim decode.
    always_comb begin
        state_next_s = state_r;
        take_s       = 1'b0;
        clr_s        = {NUM_SRC{1'b0}};
        case (state_r)
            ST_IDLE: begin
                // mret_exec in IDLE is not a return; it only suppresses the take.
                if ((|eligible_s) && mie && boundary && !mret_exec) begin
                    take_s       = 1'b1;
                    clr_s        = onehot(winner_s);
                    state_next_s = ST_TAKE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_TAKE: begin
                state_next_s = ST_HANDLER;
            end
            ST_HANDLER: begin
                if (mret_exec) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HANDLER;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, edge history, pending, mask and claim registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            irq_prev_r   <= {NUM_SRC{1'b0}};
            pending_r    <= {NUM_SRC{1'b0}};
            en_mask_r    <= {NUM_SRC{1'b0}};
            irq_id_r     <= 8'd0;
            int_taken_r  <= 1'b0;
            in_handler_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            irq_prev_r <= irq_s;
            // A fresh rise on the claimed bit wins over its clear.
            pending_r  <= (pending_r & ~clr_s) | rise_s;
            if (en_we) begin
                en_mask_r <= en_wd;
            end
            if (take_s) begin
                irq_id_r <= winner_s;
            end
            // Outputs registered from the next state so they track state_r exactly.
            int_taken_r  <= (state_next_s == ST_TAKE);
            in_handler_r <= (state_next_s == ST_TAKE) || (state_next_s == ST_HANDLER);
        end
    end

    assign en_mask    = en_mask_r;
    assign pending    = pending_r;
    assign int_taken  = int_taken_r;
    assign irq_id     = irq_id_r;
    assign in_handler = in_handler_r;

endmodule

// File: tb/tb_intc_trap_seq.sv
// ---------------------------------------------------------------------------
// tb_intc_trap_seq
//   Directed self-checking bench for intc_trap_seq (NUM_SRC=4, macro
//   undefined). Inputs change and outputs are sampled 1 time unit after
//   each rising clock edge.
// ---------------------------------------------------------------------------
module tb_intc_trap_seq;

    logic       clk;
    logic       reset;
    logic [3:0] irq_in;
    logic       mie;
    logic       boundary;
    logic       mret_exec;
    logic       en_we;
    logic [3:0] en_wd;
    logic [3:0] en_mask;
    logic [3:0] pending;
    logic       int_taken;
    logic [7:0] irq_id;
    logic       in_handler;

    int checks;
    int errors;
    int n_taken;

    intc_trap_seq #(.NUM_SRC(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mie        (mie),
        .boundary   (boundary),
        .mret_exec  (mret_exec),
        .en_we      (en_we),
        .en_wd      (en_wd),
        .en_mask    (en_mask),
        .pending    (pending),
        .int_taken  (int_taken),
        .irq_id     (irq_id),
        .in_handler (in_handler)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 time unit past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count a comparison and report a mismatch.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse mret_exec for one edge while in HANDLER.
    task automatic do_mret();
        mret_exec = 1'b1;
        tick();
        mret_exec = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        irq_in    = 4'b0000;
        mie       = 1'b1;
        boundary  = 1'b1;
        mret_exec = 1'b0;
        en_we     = 1'b0;
        en_wd     = 4'b0000;
        tick();
        tick();
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_mask", 32'(en_mask), 32'h0);
        chk("rst_taken", 32'(int_taken), 32'h0);
        chk("rst_id", 32'(irq_id), 32'h0);
        chk("rst_hdl", 32'(in_handler), 32'h0);
        reset = 1'b0;
        tick();

        // Basic take
        en_we = 1'b1; en_wd = 4'b1111;
        tick();
        en_we = 1'b0;
        chk("mask_wr", 32'(en_mask), 32'hF);
        irq_in = 4'b0100;
        tick();
        chk("basic_pend", 32'(pending), 32'h4);
        chk("basic_notake", 32'(int_taken), 32'h0);
        tick();
        chk("basic_taken", 32'(int_taken), 32'h1);
        chk("basic_id", 32'(irq_id), 32'h2);
        chk("basic_clr", 32'(pending), 32'h0);
        chk("basic_hdl", 32'(in_handler), 32'h1);
        irq_in = 4'b0000;
        tick();
        chk("basic_pulse", 32'(int_taken), 32'h0);
        tick();
        tick();
        chk("basic_hdl_hold", 32'(in_handler), 32'h1);
        do_mret();
        chk("basic_ret", 32'(in_handler), 32'h0);
        chk("basic_ret_taken", 32'(int_taken), 32'h0);

        // Priority
        irq_in = 4'b1010;
        tick();
        chk("prio_pend", 32'(pending), 32'hA);
        tick();
        chk("prio_taken1", 32'(int_taken), 32'h1);
        chk("prio_id1", 32'(irq_id), 32'h1);
        chk("prio_pend1", 32'(pending), 32'h8);
        irq_in = 4'b0000;
        tick();
        tick();
        chk("prio_blocked", 32'(int_taken), 32'h0);
        do_mret();
        chk("prio_idle", 32'(in_handler), 32'h0);
        tick();
        chk("prio_taken2", 32'(int_taken), 32'h1);
        chk("prio_id2", 32'(irq_id), 32'h3);
        chk("prio_pend2", 32'(pending), 32'h0);
        tick();
        do_mret();

        // Masking
        en_we = 1'b1; en_wd = 4'b0000;
        tick();
        en_we = 1'b0;
        irq_in = 4'b0001;
        tick();
        chk("mask_pend", 32'(pending), 32'h1);
        n_taken = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (int_taken) n_taken++;
        end
        chk("mask_hold", 32'(n_taken), 32'h0);
        chk("mask_pend_kept", 32'(pending), 32'h1);
        en_we = 1'b1; en_wd = 4'b0001;
        tick();
        en_we = 1'b0;
        chk("mask_new_pend", 32'(pending), 32'h1);
        tick();
        chk("mask_taken", 32'(int_taken), 32'h1);
        chk("mask_id", 32'(irq_id), 32'h0);
        irq_in = 4'b0000;
        tick();
        do_mret();

        // Gating by mie and boundary
        en_we = 1'b1; en_wd = 4'b1111;
        tick();
        en_we = 1'b0;
        mie = 1'b0;
        irq_in = 4'b0010;
        tick();
        chk("gate_pend", 32'(pending), 32'h2);
        n_taken = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (int_taken) n_taken++;
        end
        chk("gate_mie", 32'(n_taken), 32'h0);
        mie = 1'b1; boundary = 1'b0;
        n_taken = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (int_taken) n_taken++;
        end
        chk("gate_bnd", 32'(n_taken), 32'h0);
        boundary = 1'b1;
        irq_in = 4'b0000;
        tick();
        chk("gate_taken", 32'(int_taken), 32'h1);
        chk("gate_id", 32'(irq_id), 32'h1);
        tick();

        // Nested hold inside HANDLER
        irq_in = 4'b0001;
        tick();
        chk("nest_pend", 32'(pending), 32'h1);
        chk("nest_notake", 32'(int_taken), 32'h0);
        tick();
        tick();
        chk("nest_hold", 32'(int_taken), 32'h0);
        chk("nest_hdl", 32'(in_handler), 32'h1);
        do_mret();
        tick();
        chk("nest_taken", 32'(int_taken), 32'h1);
        chk("nest_id", 32'(irq_id), 32'h0);
        chk("nest_clr", 32'(pending), 32'h0);
        irq_in = 4'b0100;
        tick();
        chk("nest_pend2", 32'(pending), 32'h4);

        // Asynchronous reset mid-HANDLER
        #2;
        reset = 1'b1;
        #1;
        chk("arst_hdl", 32'(in_handler), 32'h0);
        chk("arst_pend", 32'(pending), 32'h0);
        chk("arst_id", 32'(irq_id), 32'h0);
        chk("arst_mask", 32'(en_mask), 32'h0);
        tick();
        reset = 1'b0;
        // irq_in[2] still high: one edge registers at the first clock
        tick();
        chk("rel_edge", 32'(pending), 32'h4);
        tick();
        chk("rel_nomask", 32'(int_taken), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
